oct_scan_sequencer: RTL

//  Sequences the acquisition generator over a multi-frame OCT scan. Holds a shadow

---
 rtl/oct_scan_sequencer_pkg.sv | 28 ++
 rtl/oct_scan_sequencer_if.sv | 35 +++
 rtl/oct_scan_sequencer_cfg_regs.sv | 46 ++++
 rtl/oct_scan_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/oct_scan_sequencer_pkg.sv
// Shared types and constants for the OCT scan sequencer.
package oct_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5,
    S_ABORT = 3'd6,
    S_FAULT = 3'd7
  } seq_state_t;

  localparam logic [2:0] ADDR_XPTS   = 3'd0;
  localparam logic [2:0] ADDR_XBLK   = 3'd1;
  localparam logic [2:0] ADDR_YPTS   = 3'd2;
  localparam logic [2:0] ADDR_CPP    = 3'd3;
  localparam logic [2:0] ADDR_DELAY  = 3'd4;
  localparam logic [2:0] ADDR_FRAMES = 3'd5;
  localparam logic [2:0] ADDR_GAP    = 3'd6;

  // Shortest inter-frame dwell; gives the generator time to drop its finished flag.
  localparam int GAP_MIN_DEF   = 2;
  // Number of cycles the generator is held in reset on abort or watchdog fault.
  localparam int ABORT_RST_CYC = 2;

endpackage

// File: rtl/oct_scan_sequencer_if.sv
// Bus bundle between a host/generator side (master) and the sequencer (slave).
interface oct_seq_if #(parameter int CW = 16) ();

  logic          cfg_we;
  logic [2:0]    cfg_addr;
  logic [CW-1:0] cfg_wdata;
  logic          start;
  logic          abort;
  logic          gen_finished;

  logic          gen_data_rdy;
  logic          gen_rstn;
  logic [CW-1:0] gen_xpoints;
  logic [CW-1:0] gen_xblock;
  logic [CW-1:0] gen_ypoints;
  logic [CW-1:0] gen_cpp;
  logic [CW-1:0] gen_delay;
  logic          busy;
  logic [CW-1:0] frame_cnt;
  logic          done;
  logic          fault;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, start, abort, gen_finished,
    input  gen_data_rdy, gen_rstn, gen_xpoints, gen_xblock, gen_ypoints,
           gen_cpp, gen_delay, busy, frame_cnt, done, fault
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, start, abort, gen_finished,
    output gen_data_rdy, gen_rstn, gen_xpoints, gen_xblock, gen_ypoints,
           gen_cpp, gen_delay, busy, frame_cnt, done, fault
  );

endinterface

// File: rtl/oct_scan_sequencer_cfg_regs.sv
// Shadow configuration register file; writes land here at any time and are
// only copied to the generator-facing registers when a scan starts.
module oct_seq_cfg_regs
  import oct_seq_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [2:0]    addr,
  input  logic [CW-1:0] wdata,
  output logic [CW-1:0] xpoints,
  output logic [CW-1:0] xblock,
  output logic [CW-1:0] ypoints,
  output logic [CW-1:0] cpp,
  output logic [CW-1:0] delay,
  output logic [CW-1:0] frames,
  output logic [CW-1:0] gap
);

  // Address decode and write; address 7 is not mapped and is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xpoints <= '0;
      xblock  <= '0;
      ypoints <= '0;
      cpp     <= '0;
      delay   <= '0;
      frames  <= '0;
      gap     <= '0;
    end else if (we) begin
      case (addr)
        ADDR_XPTS:   xpoints <= wdata;
        ADDR_XBLK:   xblock  <= wdata;
        ADDR_YPTS:   ypoints <= wdata;
        ADDR_CPP:    cpp     <= wdata;
        ADDR_DELAY:  delay   <= wdata;
        ADDR_FRAMES: frames  <= wdata;
        ADDR_GAP:    gap     <= wdata;
        default:     ;
      endcase
    end
  end

endmodule

// File: rtl/oct_scan_sequencer.sv
// Multi-frame OCT scan sequencer: launches one generator frame per ARM, counts
// finished frames, inserts an inter-frame gap and handles abort.
// Optional feature macro: OCT_SEQ_WATCHDOG_EN (RUN-state timeout -> FAULT).
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | copy shadow config to active regs, clear frame count
// ARM   | gen_data_rdy high for this cycle
// RUN   | waiting for rising edge of gen_finished
// GAP   | inter-frame dwell of max(gap, GAP_MIN) cycles
// DONE  | done high for this cycle
// ABORT | generator held in reset for ABORT_RST_CYC cycles
// FAULT | watchdog tripped; held busy until abort
module oct_scan_sequencer
  import oct_seq_pkg::*;
#(
  parameter int CW      = 16,
  parameter int GAP_MIN = GAP_MIN_DEF
`ifdef OCT_SEQ_WATCHDOG_EN
  , parameter int WDOG_CYC = 2**24
`endif
) (
  input logic       clk,
  input logic       rst,
  oct_seq_if.slave  bus
);

  localparam logic [CW-1:0] GAP_MIN_W = CW'(GAP_MIN);
  localparam logic [1:0]    RST_LAST  = 2'(ABORT_RST_CYC - 1);

  logic [CW-1:0] sh_xpoints, sh_xblock, sh_ypoints, sh_cpp, sh_delay, sh_frames, sh_gap;
  logic [CW-1:0] act_xpoints, act_xblock, act_ypoints, act_cpp, act_delay;
  logic [CW-1:0] frames_q, gap_q, gap_cnt, frame_cnt_q;
  logic [CW-1:0] frame_nxt, dwell;
  logic [1:0]    rst_cnt;
  logic          data_rdy_q, rstn_q, busy_q, done_q;
  logic          fin_q, fin_rise;
  seq_state_t    state;

`ifdef OCT_SEQ_WATCHDOG_EN
  localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYC - 1);
  logic [31:0] wdog_cnt;
  logic        fault_q;
`endif

  oct_seq_cfg_regs #(.CW(CW)) u_cfg_regs (
    .clk     (clk),
    .rst     (rst),
    .we      (bus.cfg_we),
    .addr    (bus.cfg_addr),
    .wdata   (bus.cfg_wdata),
    .xpoints (sh_xpoints),
    .xblock  (sh_xblock),
    .ypoints (sh_ypoints),
    .cpp     (sh_cpp),
    .delay   (sh_delay),
    .frames  (sh_frames),
    .gap     (sh_gap)
  );

  assign fin_rise  = bus.gen_finished & ~fin_q;
  assign frame_nxt = frame_cnt_q + 1'b1;
  // Unsigned compare: a gap shorter than GAP_MIN is stretched to GAP_MIN.
  assign dwell     = (gap_q < GAP_MIN_W) ? GAP_MIN_W : gap_q;

  // Previous value of gen_finished for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fin_q <= 1'b0;
    else     fin_q <= bus.gen_finished;
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      act_xpoints <= '0;
      act_xblock  <= '0;
      act_ypoints <= '0;
      act_cpp     <= '0;
      act_delay   <= '0;
      frames_q    <= '0;
      gap_q       <= '0;
      gap_cnt     <= '0;
      frame_cnt_q <= '0;
      rst_cnt     <= '0;
      data_rdy_q  <= 1'b0;
      rstn_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef OCT_SEQ_WATCHDOG_EN
      wdog_cnt    <= '0;
      fault_q     <= 1'b0;
`endif
    end else begin
      data_rdy_q <= 1'b0;
      done_q     <= 1'b0;
      rstn_q     <= 1'b1;
      // Abort wins over everything, including a same-cycle finished edge.
      if (bus.abort && state != S_IDLE && state != S_FAULT) begin
        state   <= S_ABORT;
        rstn_q  <= 1'b0;
        rst_cnt <= '0;
        busy_q  <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start && !bus.abort) begin
              state  <= S_LOAD;
              busy_q <= 1'b1;
            end
          end
          S_LOAD: begin
            act_xpoints <= sh_xpoints;
            act_xblock  <= sh_xblock;
            act_ypoints <= sh_ypoints;
            act_cpp     <= sh_cpp;
            act_delay   <= sh_delay;
            frames_q    <= sh_frames;
            gap_q       <= sh_gap;
            frame_cnt_q <= '0;
            state       <= S_ARM;
            data_rdy_q  <= 1'b1;
          end
          S_ARM: begin
            state <= S_RUN;
`ifdef OCT_SEQ_WATCHDOG_EN
            wdog_cnt <= '0;
`endif
          end
          S_RUN: begin
            if (fin_rise) begin
              frame_cnt_q <= frame_nxt;
              if (frames_q != '0 && frame_nxt == frames_q) begin
                state  <= S_DONE;
                done_q <= 1'b1;
              end else begin
                state   <= S_GAP;
                gap_cnt <= dwell - 1'b1;
              end
            end
`ifdef OCT_SEQ_WATCHDOG_EN
            else if (wdog_cnt == WDOG_LAST) begin
              state   <= S_FAULT;
              fault_q <= 1'b1;
              rstn_q  <= 1'b0;
              rst_cnt <= '0;
            end else begin
              wdog_cnt <= wdog_cnt + 1'b1;
            end
`endif
          end
          S_GAP: begin
            if (gap_cnt == '0) begin
              state      <= S_ARM;
              data_rdy_q <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end
          S_DONE: begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
          S_ABORT: begin
            if (rst_cnt == RST_LAST) begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end else begin
              rst_cnt <= rst_cnt + 1'b1;
              rstn_q  <= 1'b0;
            end
          end
          S_FAULT: begin
`ifdef OCT_SEQ_WATCHDOG_EN
            if (bus.abort) begin
              state   <= S_IDLE;
              busy_q  <= 1'b0;
              fault_q <= 1'b0;
            end else if (rst_cnt != RST_LAST) begin
              rst_cnt <= rst_cnt + 1'b1;
              rstn_q  <= 1'b0;
            end
`else
            state  <= S_IDLE;
            busy_q <= 1'b0;
`endif
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.gen_data_rdy = data_rdy_q;
  assign bus.gen_rstn     = rstn_q;
  assign bus.gen_xpoints  = act_xpoints;
  assign bus.gen_xblock   = act_xblock;
  assign bus.gen_ypoints  = act_ypoints;
  assign bus.gen_cpp      = act_cpp;
  assign bus.gen_delay    = act_delay;
  assign bus.busy         = busy_q;
  assign bus.frame_cnt    = frame_cnt_q;
  assign bus.done         = done_q;
`ifdef OCT_SEQ_WATCHDOG_EN
  assign bus.fault        = fault_q;
`else
  assign bus.fault        = 1'b0;
`endif

endmodule
